// File: rtl/main_memory_controller_pkg.sv
// Shared constants and types for the main memory controller and its arbiter.
package main_memory_controller_pkg;

  localparam int MAIN_MEMORY_ADDRESS_WIDTH  = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH     = 128;
  localparam int MAIN_MEMORY_BLOCK_SIZE     = 4;
  localparam int MAIN_MEMORY_SIZE           = 256;
  localparam int MAIN_MEMORY_NUM_BLOCKS     = MAIN_MEMORY_SIZE / MAIN_MEMORY_BLOCK_SIZE;
  localparam int MAIN_MEMORY_LATENCY        = 4;
  localparam int MAIN_MEMORY_WORDS_PER_LINE = MAIN_MEMORY_DATA_WIDTH / 32;
  localparam int MAIN_MEMORY_BLOCK_IDX_W    = $clog2(MAIN_MEMORY_NUM_BLOCKS);

  typedef enum logic [1:0] {MMC_IDLE, MMC_ACCESS, MMC_RESP} mmc_state_t;

  typedef logic [MAIN_MEMORY_DATA_WIDTH-1:0] mm_line_t;

  // Block k of a line sits at {line, k}; the line field is addr[7:4].
  function automatic logic [MAIN_MEMORY_BLOCK_IDX_W-1:0] block_index(input logic [3:0] line,
                                                                    input logic [1:0] k);
    return {line, k};
  endfunction

endpackage

// File: rtl/mm_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant plus the last-served register.
module mm_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       rr_last,
  output logic [1:0] gnt
);

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset value 1 lets port 0 win the very first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/main_memory_controller.sv
// Main memory array shared by the L2 refill (port 0) and writeback (port 1) paths,
// one fixed-latency line transfer in flight at a time.
module main_memory_controller
  import main_memory_controller_pkg::*;
#(
  parameter int MEM_LATENCY = MAIN_MEMORY_LATENCY,
  parameter int ADDR_W      = MAIN_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_W      = MAIN_MEMORY_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [31:0]       mem [MAIN_MEMORY_NUM_BLOCKS];
  mmc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_port;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_line;
  logic [3:0]        line;
  logic              oor;
  logic              commit;
  logic              rr_last;
  logic [1:0]        gnt;
  logic              advance;

  assign advance = (state == MMC_IDLE);
  assign line    = addr_q[7:4];
  assign oor     = (addr_q >= ADDR_W'(MAIN_MEMORY_SIZE));
  assign commit  = (state == MMC_ACCESS) && (cnt == '0) && we_q && !oor;

  mm_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .rr_last (rr_last),
    .gnt     (gnt)
  );

  always_comb begin
    mem_line = '0;
    for (int k = 0; k < MAIN_MEMORY_WORDS_PER_LINE; k++) begin
      mem_line[32*k +: 32] = mem[block_index(line, k[1:0])];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAIN_MEMORY_NUM_BLOCKS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int k = 0; k < MAIN_MEMORY_WORDS_PER_LINE; k++) begin
        mem[block_index(line, k[1:0])] <= wdata_q[32*k +: 32];
      end
    end
  end

  // A write answers with the line it just committed, so the response never sees stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MMC_IDLE;
      cnt      <= '0;
      gnt_port <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack      <= 2'b00;
      err      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        MMC_IDLE: begin
          ack <= 2'b00;
          if (gnt != 2'b00) begin
            gnt_port <= gnt[1];
            we_q     <= we[gnt[1]];
            addr_q   <= gnt[1] ? addr1 : addr0;
            wdata_q  <= gnt[1] ? wdata1 : wdata0;
            cnt      <= CNT_W'(MEM_LATENCY - 1);
            busy     <= 1'b1;
            state    <= MMC_ACCESS;
          end
        end
        MMC_ACCESS: begin
          if (cnt == '0) begin
            ack   <= gnt_port ? 2'b10 : 2'b01;
            err   <= oor;
            rdata <= oor ? '0 : (we_q ? wdata_q : mem_line);
            state <= MMC_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MMC_RESP: begin
          ack   <= 2'b00;
          err   <= 1'b0;
          rdata <= '0;
          busy  <= 1'b0;
          state <= MMC_IDLE;
        end
        default: begin
          state <= MMC_IDLE;
        end
      endcase
    end
  end

  // With both ports requesting, the port not served last must be the one granted.
  assert property (@(posedge clk) disable iff (reset)
    (state == MMC_IDLE && req == 2'b11) |-> (gnt[0] == rr_last));

endmodule

// File: tb/tb_main_memory_controller.sv
// Directed self-checking bench for main_memory_controller: transfers, arbitration, range errors and reset abort.
module tb_main_memory_controller;

  logic         clk;
  logic         reset;
  logic [1:0]   req;
  logic [1:0]   we;
  logic [31:0]  addr0;
  logic [31:0]  addr1;
  logic [127:0] wdata0;
  logic [127:0] wdata1;
  logic [1:0]   ack;
  logic         err;
  logic [127:0] rdata;
  logic         busy;

  int check_count = 0;
  int pass_count  = 0;

  localparam logic [127:0] D1 = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] D4 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D5 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;

  main_memory_controller dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    req   = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("idle_timeout", {127'd0, busy}, 128'd0);
  endtask

  task automatic applyStimulus(input int port, input logic w, input logic [31:0] a, input logic [127:0] d,
                               output logic [127:0] rd, output logic er, output logic [1:0] ackv, output int lat);
    waitIdle();
    if (port == 0) begin
      addr0 = a; wdata0 = d; we[0] = w;
    end else begin
      addr1 = a; wdata1 = d; we[1] = w;
    end
    req[port] = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (ack != 2'b00) break;
    end
    ackv = ack;
    rd   = rdata;
    er   = err;
    req[port] = 1'b0;
  endtask

  task automatic doTransfer(input string tag, input int port, input logic w, input logic [31:0] a,
                            input logic [127:0] d, input logic exp_err, input logic [127:0] exp_rdata);
    logic [127:0] rd;
    logic         er;
    logic [1:0]   ackv;
    int           lat;
    applyStimulus(port, w, a, d, rd, er, ackv, lat);
    checkOutput({tag, "_ack"}, {126'd0, ackv}, (port == 0) ? 128'd1 : 128'd2);
    checkOutput({tag, "_lat"}, 128'(lat), 128'd5);
    checkOutput({tag, "_err"}, {127'd0, er}, {127'd0, exp_err});
    checkOutput({tag, "_rdata"}, rd, exp_rdata);
  endtask

  // Both ports raise req on the same edge; each drops as soon as it is acked.
  task automatic arbPair(input string tag, input int first);
    int n = 0;
    int t0 = 0;
    int t1 = 0;
    waitIdle();
    we = 2'b00; addr0 = 32'h0; addr1 = 32'h0;
    req = 2'b11;
    while (n < 40 && req != 2'b00) begin
      @(posedge clk);
      #1 n++;
      if (ack == 2'b11) checkOutput({tag, "_onehot"}, {126'd0, ack}, 128'd1);
      if (ack[0]) begin t0 = n; req[0] = 1'b0; end
      if (ack[1]) begin t1 = n; req[1] = 1'b0; end
    end
    req = 2'b00;
    checkOutput({tag, "_p0_time"}, 128'(t0), (first == 0) ? 128'd5 : 128'd11);
    checkOutput({tag, "_p1_time"}, 128'(t1), (first == 0) ? 128'd11 : 128'd5);
  endtask

  initial begin
    int n;
    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    doReset();
    checkOutput("reset_ack", {126'd0, ack}, 128'd0);
    checkOutput("reset_err", {127'd0, err}, 128'd0);
    checkOutput("reset_rdata", rdata, 128'd0);
    checkOutput("reset_busy", {127'd0, busy}, 128'd0);

    doTransfer("wr_10", 1, 1'b1, 32'h10, D1, 1'b0, D1);
    doTransfer("rd_10", 0, 1'b0, 32'h10, '0, 1'b0, D1);
    doTransfer("wr_24", 1, 1'b1, 32'h24, D2, 1'b0, D2);
    doTransfer("rd_20", 0, 1'b0, 32'h20, '0, 1'b0, D2);

    doTransfer("wr_f4", 1, 1'b1, 32'hF4, D3, 1'b0, D3);
    doTransfer("rd_1f4", 0, 1'b0, 32'h1F4, '0, 1'b1, 128'd0);
    doTransfer("wr_100", 1, 1'b1, 32'h100, D4, 1'b1, 128'd0);
    doTransfer("rd_00", 0, 1'b0, 32'h00, '0, 1'b0, 128'd0);
    doTransfer("rd_f0", 0, 1'b0, 32'hF0, '0, 1'b0, D3);

    // Port 0 drops req and moves its address one cycle after grant.
    waitIdle();
    addr0 = 32'h20; we[0] = 1'b0; req[0] = 1'b1;
    n = 0;
    repeat (2) begin
      @(posedge clk);
      #1 n++;
    end
    req[0] = 1'b0;
    addr0 = 32'h10;
    while (n < 40 && ack == 2'b00) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("drop_ack", {126'd0, ack}, 128'd1);
    checkOutput("drop_lat", 128'(n), 128'd5);
    checkOutput("drop_rdata", rdata, D2);
    doTransfer("after_drop", 0, 1'b0, 32'h10, '0, 1'b0, D1);

    doReset();
    arbPair("arb1", 0);
    doTransfer("arb_single", 0, 1'b0, 32'h0, '0, 1'b0, 128'd0);
    arbPair("arb2", 1);

    // Reset two cycles into a write must abort it without any ack or commit.
    waitIdle();
    addr1 = 32'h30; wdata1 = D5; we[1] = 1'b1; req[1] = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1 checkOutput("rst_mid_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_mid_ack", {126'd0, ack}, 128'd0);
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (ack != 2'b00) n++;
    end
    checkOutput("rst_mid_no_ack", 128'(n), 128'd0);
    doTransfer("rd_30", 0, 1'b0, 32'h30, '0, 1'b0, 128'd0);
    doTransfer("rd_10_cleared", 0, 1'b0, 32'h10, '0, 1'b0, 128'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
